zoom_sequence_ctrl: RTL and testbench

//  Autoplay/step controller for the zoom datapath: selects zoom_level, launches one

---
 rtl/zoom_ctrl_pkg.sv | 34 +++
 rtl/zoom_tick_gen.sv | 49 ++++
 rtl/zoom_sequence_ctrl.sv | 174 +++++++++++++++++
 tb/tb_zoom_sequence_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zoom_ctrl_pkg
// Description : Shared types and elaboration-time helpers for the zoom
//               sequence controller: FSM state encoding, ping-pong direction
//               encoding, and the prescaler period / counter width functions.
// Revision    : 1.0 - initial release
// ============================================================================
package zoom_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_DWELL     = 2'd3
    } zoom_state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } zoom_dir_e;

    // Prescaler period in input clock cycles.
    function automatic int calc_period(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width of a counter holding 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : zoom_ctrl_pkg
`default_nettype wire

// File: rtl/zoom_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : zoom_tick_gen
// Description : Dwell-tick prescaler. Counts 0..PERIOD-1 while run_i is high
//               and clear_i is low; tick_o is a registered one-cycle pulse in
//               the cycle after the terminal count. Clear or stop resets both
//               the count and the pending tick.
// Ports       : clk_i   - clock
//               rst_i   - synchronous active-high reset
//               run_i   - count enable
//               clear_i - synchronous clear (dominates run_i)
//               tick_o  - terminal-count pulse
// Revision    : 1.0 - initial release
// ============================================================================
module zoom_tick_gen
    import zoom_ctrl_pkg::*;
#(
    parameter int PERIOD = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int              CNT_W    = cnt_width(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i || !run_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;

endmodule : zoom_tick_gen
`default_nettype wire

// File: rtl/zoom_sequence_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : zoom_sequence_ctrl
// Description : Autoplay / manual-step controller for the zoom datapath.
//               Selects zoom_level, launches one pass per level with a
//               start/done handshake, then dwells HOLD_TICKS prescaled ticks
//               before auto-advancing. Build option ZOOM_SEQ_PINGPONG_EN
//               selects ping-pong level advance instead of wrap-around.
// Ports       : clk_50mhz  - clock
//               rst        - synchronous active-high reset
//               enable     - autoplay run level
//               step_req   - manual advance pulse
//               zoom_done  - datapath pass complete pulse
//               zoom_start - pass launch pulse (registered)
//               zoom_level - current level (registered, stable while busy)
//               busy       - high in LAUNCH and WAIT_DONE (registered)
//               tick       - prescaler pulse (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module zoom_sequence_ctrl
    import zoom_ctrl_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 2,
    parameter int HOLD_TICKS = 4,
    parameter int NUM_LEVELS = 4,
    parameter int LEVEL_W    = 2
) (
    input  logic               clk_50mhz,
    input  logic               rst,
    input  logic               enable,
    input  logic               step_req,
    input  logic               zoom_done,
    output logic               zoom_start,
    output logic [LEVEL_W-1:0] zoom_level,
    output logic               busy,
    output logic               tick
);

    localparam int                  PERIOD     = calc_period(CLK_HZ, TICK_HZ);
    localparam int                  DWELL_W    = cnt_width(HOLD_TICKS);
    localparam logic [DWELL_W-1:0]  DWELL_LAST = DWELL_W'(HOLD_TICKS - 1);
    localparam logic [LEVEL_W-1:0]  LEVEL_LAST = LEVEL_W'(NUM_LEVELS - 1);

    zoom_state_e        state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [LEVEL_W-1:0] level_q, level_d, adv_level;
    logic               start_q, busy_q;
    logic               do_adv;
    logic               tick_w;

    // The prescaler only runs while the FSM stays in DWELL, so every DWELL
    // entry starts from a zero count and no tick can leak out of DWELL.
    zoom_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick_gen (
        .clk_i   (clk_50mhz),
        .rst_i   (rst),
        .run_i   (state_q == ST_DWELL),
        .clear_i (state_d != ST_DWELL),
        .tick_o  (tick_w)
    );

`ifdef ZOOM_SEQ_PINGPONG_EN
    zoom_dir_e dir_q, dir_d, adv_dir;

    // Bounce between 0 and LEVEL_LAST; a single level never moves.
    always_comb begin
        adv_level = level_q;
        adv_dir   = dir_q;
        if (NUM_LEVELS > 1) begin
            if (dir_q == DIR_UP) begin
                if (level_q == LEVEL_LAST) begin
                    adv_level = level_q - 1'b1;
                    adv_dir   = DIR_DOWN;
                end else begin
                    adv_level = level_q + 1'b1;
                end
            end else begin
                if (level_q == '0) begin
                    adv_level = level_q + 1'b1;
                    adv_dir   = DIR_UP;
                end else begin
                    adv_level = level_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        dir_d = do_adv ? adv_dir : dir_q;
    end
`else
    // Wrap-around; with one level LEVEL_LAST is 0, so the level holds at 0.
    always_comb begin
        adv_level = (level_q == LEVEL_LAST) ? '0 : level_q + 1'b1;
    end
`endif

    // Next-state logic. A step and the final tick in the same cycle share
    // one do_adv, so the level only ever moves by one per launch.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        do_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (step_req) begin
                    do_adv  = 1'b1;
                    state_d = ST_LAUNCH;
                end else if (enable) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (zoom_done) begin
                    state_d = ST_DWELL;
                    dwell_d = '0;
                end
            end
            ST_DWELL: begin
                if (step_req) begin
                    do_adv  = 1'b1;
                    state_d = ST_LAUNCH;
                end else if (tick_w && (dwell_q == DWELL_LAST) && enable) begin
                    do_adv  = 1'b1;
                    state_d = ST_LAUNCH;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else if (tick_w) begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        level_d = do_adv ? adv_level : level_q;
    end

    // State and registered outputs; outputs are derived from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dwell_q <= '0;
            level_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ZOOM_SEQ_PINGPONG_EN
            dir_q   <= DIR_UP;
`endif
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            level_q <= level_d;
            start_q <= (state_d == ST_LAUNCH);
            busy_q  <= (state_d == ST_LAUNCH) || (state_d == ST_WAIT_DONE);
`ifdef ZOOM_SEQ_PINGPONG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign zoom_start = start_q;
    assign zoom_level = level_q;
    assign busy       = busy_q;
    assign tick       = tick_w;

endmodule : zoom_sequence_ctrl
`default_nettype wire

// File: tb/tb_zoom_sequence_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_zoom_sequence_ctrl
// Description : Self-checking bench for zoom_sequence_ctrl with CLK_HZ=8,
//               TICK_HZ=2 (PERIOD=4), HOLD_TICKS=2, NUM_LEVELS=4. Stimulus
//               pushes expected {level, cycle} for each launch into a queue;
//               a monitor pops on every zoom_start pulse and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zoom_sequence_ctrl;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       enable    = 1'b0;
    logic       step_req  = 1'b0;
    logic       zoom_done = 1'b0;
    logic       zoom_start;
    logic [1:0] zoom_level;
    logic       busy;
    logic       tick;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0] lvl;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

`ifdef ZOOM_SEQ_PINGPONG_EN
    localparam int         N_AUTO = 6;
    localparam logic [1:0] AUTO_SEQ [N_AUTO] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
`else
    localparam int         N_AUTO = 4;
    localparam logic [1:0] AUTO_SEQ [N_AUTO] = '{2'd1, 2'd2, 2'd3, 2'd0};
`endif

    zoom_sequence_ctrl #(
        .CLK_HZ     (8),
        .TICK_HZ    (2),
        .HOLD_TICKS (2),
        .NUM_LEVELS (4),
        .LEVEL_W    (2)
    ) dut (
        .clk_50mhz  (clk),
        .rst        (rst),
        .enable     (enable),
        .step_req   (step_req),
        .zoom_done  (zoom_done),
        .zoom_start (zoom_start),
        .zoom_level (zoom_level),
        .busy       (busy),
        .tick       (tick)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor: every launch pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (zoom_start === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_start: got start at cycle %0d level %0d, expected none",
                         cyc, zoom_level);
            end else begin
                e = sb_q.pop_front();
                check("start_level", 32'(zoom_level), 32'(e.lvl));
                check("start_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_start(output int s);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (zoom_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        s = cyc;
        if (!seen) begin
            n_total++;
            $display("FAIL start_timeout: got no start by cycle %0d, expected a start", cyc);
        end
    endtask

    task automatic pulse_done(output int d);
        @(posedge clk); #1;
        zoom_done = 1'b1;
        d = cyc;
        @(posedge clk); #1;
        zoom_done = 1'b0;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic sample_at(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int s;
        int d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_level", 32'(zoom_level), 0);
        check("rst_start", 32'(zoom_start), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_tick",  32'(tick), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Autoplay start at level 0
        @(posedge clk); #1;
        enable = 1'b1;
        sb_q.push_back('{2'd0, cyc + 1});
        wait_start(s);
        check("busy_launch", 32'(busy), 1);
        @(negedge clk);
        check("busy_wait", 32'(busy), 1);

        // Autoplay: next launch 10 cycles after the done pulse is driven
        for (int i = 0; i < N_AUTO; i++) begin
            pulse_done(d);
            sb_q.push_back('{AUTO_SEQ[i], d + 10});
            if (i == 0) begin
                sample_at(d + 4);
                check("tick_before", 32'(tick), 0);
                @(negedge clk);
                check("tick_first", 32'(tick), 1);
                @(negedge clk);
                check("tick_after", 32'(tick), 0);
            end
            wait_start(s);
        end

        // step_req during WAIT_DONE is dropped (level 0 pass in flight)
        @(posedge clk); #1;
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wait_step_busy",  32'(busy), 1);
            check("wait_step_level", 32'(zoom_level), 0);
        end

        // Real done, stray done in DWELL, then step on the final-tick cycle
        pulse_done(d);
        goto_cyc(d + 3);
        zoom_done = 1'b1;
        @(posedge clk); #1;
        zoom_done = 1'b0;
        goto_cyc(d + 9);
        step_req = 1'b1;
        sb_q.push_back('{2'd1, d + 10});
        @(posedge clk); #1;
        step_req = 1'b0;
        wait_start(s);
        repeat (6) @(negedge clk);
        check("step_tick_level", 32'(zoom_level), 1);

        // enable dropped during DWELL: back to IDLE, level held, no tick
        pulse_done(d);
        goto_cyc(d + 3);
        enable = 1'b0;
        sample_at(d + 5);
        check("idle_no_tick", 32'(tick), 0);
        sample_at(d + 15);
        check("idle_level", 32'(zoom_level), 1);
        check("idle_busy",  32'(busy), 0);

        // step_req in IDLE advances and launches
        @(posedge clk); #1;
        step_req = 1'b1;
        sb_q.push_back('{2'd2, cyc + 1});
        @(posedge clk); #1;
        step_req = 1'b0;
        wait_start(s);

        // Reset in WAIT_DONE aborts the pass
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        @(negedge clk);
        check("abort_level", 32'(zoom_level), 0);
        check("abort_busy",  32'(busy), 0);
        check("abort_start", 32'(zoom_start), 0);
        check("abort_tick",  32'(tick), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // IDLE after reset: enable relaunches at level 0
        @(posedge clk); #1;
        enable = 1'b1;
        sb_q.push_back('{2'd0, cyc + 1});
        wait_start(s);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_zoom_sequence_ctrl
`default_nettype wire
